password_ctrl: RTL
==================

# password_ctrl

Sequencing controller for the push-button password lock on the Spartan-3E board. It consumes the toggle outputs of the per-button debouncers: each debouncer output flips once per push-release, so any transition counts as one press. It sequences digit entry, code comparison, the timed unlock window and the failed-attempt lockout. It drives the lock LEDs and display digit, and sits between the debouncer bank and the LED/display drivers.

## Interface
- PASSWORD, 16'h1234: stored code, four BCD digits; digit 0 in [15:12], digit 3 in [3:0].
- MAX_FAIL, 3: consecutive wrong codes that trigger lockout; legal range 1..15.
- OPEN_CYCLES, 50_000_000: clk cycles in OPEN (1 s at 50 MHz).
- LOCK_CYCLES, 500_000_000: clk cycles in LOCK.
- clk  input  1  system clock, all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- ev_inc  input  1  debouncer toggle output, "increment digit" button.
- ev_dec  input  1  debouncer toggle output, "decrement digit" button.
- ev_enter  input  1  debouncer toggle output, "accept digit" button.
- ev_clr  input  1  debouncer toggle output, "clear / relock" button.
- cur_digit  output  4  digit being edited, BCD 0..9.
- digit_idx  output  2  position being entered, 0..3.
- unlocked  output  1  high only in OPEN.
- locked_out  output  1  high only in LOCK.
- fail_pulse  output  1  one-cycle pulse per wrong code.
- fail_cnt  output  4  consecutive wrong codes so far.

## Operation
- Event detect, per input: 3-flop chain s1<=in, s2<=s1, s3<=s2; event = s2^s3. Both edges count as events.
- Warm-up: after rst_n release, a 2-bit counter suppresses all events for the first 3 cycles. This stops a high input at reset from producing an event.
- Priority when events coincide in one cycle: clr > enter > inc > dec. Lower-priority events in that cycle are discarded.
- States: ENTRY, OPEN, LOCK. Reset enters ENTRY.
- ENTRY actions:
  - inc: cur_digit 9 wraps to 0, otherwise +1.
  - dec: cur_digit 0 wraps to 9, otherwise -1.
  - enter, idx<3: set mismatch |= (cur_digit != PASSWORD digit idx); idx+1; cur_digit <= 0.
  - enter, idx==3: match = !mismatch && cur_digit == digit 3. Then idx, cur_digit and mismatch are cleared.
    - match: go to OPEN, fail_cnt <= 0.
    - no match, fail_cnt+1 == MAX_FAIL: go to LOCK, fail_pulse=1, fail_cnt <= MAX_FAIL.
    - otherwise: stay in ENTRY, fail_pulse=1, fail_cnt+1.
  - clr: idx, cur_digit and mismatch cleared; fail_cnt is not changed.
- OPEN: unlocked=1.
  - Leave to ENTRY after exactly OPEN_CYCLES cycles, or on a clr event (early relock).
  - inc/dec/enter are ignored.
- LOCK: locked_out=1.
  - All events ignored, including clr.
  - Leave to ENTRY after exactly LOCK_CYCLES cycles, with fail_cnt <= 0.
- Timer: 32-bit, cleared on every state entry. The state exits on the edge where timer == N-1, so the dwell is exactly N cycles.

## Timing
- Reset values: cur_digit=0, digit_idx=0, unlocked=0, locked_out=0, fail_pulse=0, fail_cnt=0, state=ENTRY, timer=0, s1..s3=0.
- Event latency: an input change sampled at edge k takes effect at edge k+2, so outputs change 3 edges after the input change.
- fail_pulse is registered and high for exactly one cycle, in the cycle after the final enter is processed.
- unlocked and locked_out are registered and assert in the same cycle the state changes.
- Events landing during the warm-up cycles are lost.
- Reset mid-OPEN or mid-LOCK drops all outputs to reset values immediately, asynchronously.

## Test plan
- Correct code: warm-up done; with PASSWORD=1234 and OPEN_CYCLES=20, enter 1,2,3,4 using inc toggles and enter toggles. Required: unlocked=1 for exactly 20 cycles, fail_cnt=0, then ENTRY with digit_idx=0.
- Wrong code: enter 1,2,3,5. Required: one fail_pulse, fail_cnt=1, unlocked stays 0, digit_idx=0, cur_digit=0.
- Lockout: MAX_FAIL=3, LOCK_CYCLES=30, three wrong codes. Required: locked_out=1 for exactly 30 cycles; clr and enter toggles during LOCK have no effect; afterwards fail_cnt=0.
- Wrap: dec from 0 gives 9; inc from 9 gives 0. Each change lands 3 edges after the input toggle.
- Simultaneous: toggle ev_enter and ev_inc in the same cycle with cur_digit=2. Required: digit accepted as 2, digit_idx+1, cur_digit=0, inc discarded. Then toggle ev_clr with ev_enter: result is idx=0 only.
- Reset: hold ev_inc=1 through reset release and confirm cur_digit stays 0. Assert rst_n mid-OPEN and confirm unlocked drops to 0 at once.

Source files
------------

// File: rtl/password_ctrl.sv
// password_ctrl: sequencing controller for the push-button password lock.
// Turns debouncer toggles into single-cycle events, runs digit entry and
// code comparison, and times the unlock window and the failed-attempt lockout.
`timescale 1ns/1ps

module password_ctrl #(
    parameter logic [15:0] PASSWORD    = 16'h1234,
    parameter int unsigned MAX_FAIL    = 3,
    parameter int unsigned OPEN_CYCLES = 50_000_000,
    parameter int unsigned LOCK_CYCLES = 500_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ev_inc,
    input  logic       ev_dec,
    input  logic       ev_enter,
    input  logic       ev_clr,
    output logic [3:0] cur_digit,
    output logic [1:0] digit_idx,
    output logic       unlocked,
    output logic       locked_out,
    output logic       fail_pulse,
    output logic [3:0] fail_cnt
);

    typedef enum logic [1:0] {
        ST_ENTRY = 2'd0,
        ST_OPEN  = 2'd1,
        ST_LOCK  = 2'd2
    } state_t;

    localparam logic [31:0] OPEN_LAST = 32'(OPEN_CYCLES - 1);
    localparam logic [31:0] LOCK_LAST = 32'(LOCK_CYCLES - 1);
    localparam logic [3:0]  FAIL_MAX  = 4'(MAX_FAIL);

    // Stored code digit for an entry position; position 0 is the top nibble.
    function automatic logic [3:0] pw_digit(input logic [1:0] idx);
        case (idx)
            2'd0:    pw_digit = PASSWORD[15:12];
            2'd1:    pw_digit = PASSWORD[11:8];
            2'd2:    pw_digit = PASSWORD[7:4];
            default: pw_digit = PASSWORD[3:0];
        endcase
    endfunction

    // Bit order of the event vectors: {clr, enter, inc, dec}
    logic [3:0] sync_p0, sync_p1, sync_p2;
    logic [1:0] warm_cnt;
    logic [3:0] ev_raw;
    logic       do_clr, do_enter, do_inc, do_dec;

    state_t      state, state_n;
    logic [31:0] timer, timer_n;
    logic [3:0]  cur_digit_n, fail_cnt_n;
    logic [1:0]  digit_idx_n;
    logic        mismatch, mismatch_n;
    logic        fail_pulse_n;
    logic        match;

    // Stage 0..2: synchronise the toggles and count off the post-reset warm-up
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p0  <= 4'd0;
            sync_p1  <= 4'd0;
            sync_p2  <= 4'd0;
            warm_cnt <= 2'd0;
        end else begin
            sync_p0 <= {ev_clr, ev_enter, ev_inc, ev_dec};
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
            if (warm_cnt != 2'd3)
                warm_cnt <= warm_cnt + 2'd1;
        end
    end

    // Any toggle is an event; a fixed priority keeps only the strongest one
    assign ev_raw   = (sync_p1 ^ sync_p2) & {4{warm_cnt == 2'd3}};
    assign do_clr   = ev_raw[3];
    assign do_enter = ev_raw[2] & ~ev_raw[3];
    assign do_inc   = ev_raw[1] & ~|ev_raw[3:2];
    assign do_dec   = ev_raw[0] & ~|ev_raw[3:1];
    assign match    = !mismatch && (cur_digit == pw_digit(2'd3));

    // Next-state and datapath decisions for entry, open window and lockout
    always_comb begin
        state_n      = state;
        timer_n      = 32'd0;
        cur_digit_n  = cur_digit;
        digit_idx_n  = digit_idx;
        mismatch_n   = mismatch;
        fail_cnt_n   = fail_cnt;
        fail_pulse_n = 1'b0;
        case (state)
            ST_ENTRY: begin
                if (do_clr) begin
                    cur_digit_n = 4'd0;
                    digit_idx_n = 2'd0;
                    mismatch_n  = 1'b0;
                end else if (do_enter) begin
                    cur_digit_n = 4'd0;
                    if (digit_idx != 2'd3) begin
                        mismatch_n  = mismatch | (cur_digit != pw_digit(digit_idx));
                        digit_idx_n = digit_idx + 2'd1;
                    end else begin
                        digit_idx_n = 2'd0;
                        mismatch_n  = 1'b0;
                        if (match) begin
                            state_n    = ST_OPEN;
                            fail_cnt_n = 4'd0;
                        end else if (fail_cnt + 4'd1 == FAIL_MAX) begin
                            state_n      = ST_LOCK;
                            fail_pulse_n = 1'b1;
                            fail_cnt_n   = FAIL_MAX;
                        end else begin
                            fail_pulse_n = 1'b1;
                            fail_cnt_n   = fail_cnt + 4'd1;
                        end
                    end
                end else if (do_inc) begin
                    cur_digit_n = (cur_digit == 4'd9) ? 4'd0 : cur_digit + 4'd1;
                end else if (do_dec) begin
                    cur_digit_n = (cur_digit == 4'd0) ? 4'd9 : cur_digit - 4'd1;
                end
            end
            ST_OPEN: begin
                if (do_clr || timer == OPEN_LAST)
                    state_n = ST_ENTRY;
                else
                    timer_n = timer + 32'd1;
            end
            ST_LOCK: begin
                if (timer == LOCK_LAST) begin
                    state_n    = ST_ENTRY;
                    fail_cnt_n = 4'd0;
                end else begin
                    timer_n = timer + 32'd1;
                end
            end
            default: state_n = ST_ENTRY;
        endcase
    end

    // State, timer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_ENTRY;
            timer      <= 32'd0;
            cur_digit  <= 4'd0;
            digit_idx  <= 2'd0;
            mismatch   <= 1'b0;
            fail_cnt   <= 4'd0;
            fail_pulse <= 1'b0;
            unlocked   <= 1'b0;
            locked_out <= 1'b0;
        end else begin
            state      <= state_n;
            timer      <= timer_n;
            cur_digit  <= cur_digit_n;
            digit_idx  <= digit_idx_n;
            mismatch   <= mismatch_n;
            fail_cnt   <= fail_cnt_n;
            fail_pulse <= fail_pulse_n;
            unlocked   <= (state_n == ST_OPEN);
            locked_out <= (state_n == ST_LOCK);
        end
    end

endmodule
